operand_fetch: RTL

- Initiator side of the RV32I register-file read/write interface.
- Accepts decoded instructions, drives the two register-file read addresses and captures the operands into an output pipeline register.
- Tracks pending destination writes in a 32-entry busy scoreboard. Stalls on RAW/WAW hazards and forwards same-cycle writeback data.
- Sits between decode and execute.

---
 rtl/rv32_pkg.sv | 9 +
 rtl/of_scoreboard.sv | 44 ++++
 rtl/operand_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I register-file constants
package rv32_pkg;
  localparam int XLEN        = 32;
  localparam int REG_AW      = 5;
  localparam int REG_NUM     = 32;
  localparam int REG_X0      = 0;
  localparam int CTRL_W      = 16;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/of_scoreboard.sv
// rtl/of_scoreboard.sv - busy bit per architectural register with set-wins update
module of_scoreboard
  import rv32_pkg::*;
#(
  parameter int AW  = REG_AW,
  parameter int NUM = REG_NUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1_idx,
  input  logic [AW-1:0] rs2_idx,
  input  logic [AW-1:0] rd_idx,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy
);

  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  logic [NUM-1:0] busy;
  logic [NUM-1:0] busy_next;

  // Clear applied first so a same-index set in the same cycle wins.
  always_comb begin
    busy_next = busy;
    if (clr_en && clr_idx != X0) busy_next[clr_idx] = 1'b0;
    if (set_en && set_idx != X0) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_idx];
  assign rs2_busy = busy[rs2_idx];
  assign rd_busy  = busy[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: hazard stall, writeback forwarding, output register
module operand_fetch #(
  parameter int XLEN        = rv32_pkg::XLEN,
  parameter int REG_AW      = rv32_pkg::REG_AW,
  parameter int CTRL_W      = rv32_pkg::CTRL_W,
  parameter int STALL_CNT_W = rv32_pkg::STALL_CNT_W
) (
  input  logic                   Clk,
  input  logic                   _Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_AW-1:0]      in_rs1,
  input  logic [REG_AW-1:0]      in_rs2,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic                   in_rd_we,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic [REG_AW-1:0]      rf_addr_1,
  output logic [REG_AW-1:0]      rf_addr_2,
  input  logic [XLEN-1:0]        rf_data_1,
  input  logic [XLEN-1:0]        rf_data_2,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [REG_AW-1:0]      out_rd,
  output logic                   out_rd_we,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(rv32_pkg::REG_X0);

  logic rs1_busy, rs2_busy, rd_busy;
  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic raw1, raw2, waw, hazard, accept;
  logic [XLEN-1:0] op1, op2;

  assign rf_addr_1 = in_rs1;
  assign rf_addr_2 = in_rs2;

  assign wb_hit1   = wb_valid && (wb_rd == in_rs1);
  assign wb_hit2   = wb_valid && (wb_rd == in_rs2);
  assign wb_hit_rd = wb_valid && (wb_rd == in_rd);

  // A writeback landing this cycle resolves the hazard on its register.
  assign raw1   = in_use_rs1 && (in_rs1 != X0) && rs1_busy && !wb_hit1;
  assign raw2   = in_use_rs2 && (in_rs2 != X0) && rs2_busy && !wb_hit2;
  assign waw    = in_rd_we   && (in_rd  != X0) && rd_busy  && !wb_hit_rd;
  assign hazard = raw1 || raw2 || waw;

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  function automatic logic [XLEN-1:0] pick(input logic use_src, input logic [REG_AW-1:0] addr,
                                           input logic wb_hit, input logic [XLEN-1:0] wb_val,
                                           input logic [XLEN-1:0] rf_val);
    if (!use_src || addr == X0) return '0;
    if (wb_hit) return wb_val;
    return rf_val;
  endfunction

  assign op1 = pick(in_use_rs1, in_rs1, wb_hit1, wb_data, rf_data_1);
  assign op2 = pick(in_use_rs2, in_rs2, wb_hit2, wb_data, rf_data_2);

  of_scoreboard #(
    .AW  (REG_AW),
    .NUM (2 ** REG_AW)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (_Reset),
    .set_en   (accept && in_rd_we),
    .set_idx  (in_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rs1_idx  (in_rs1),
    .rs2_idx  (in_rs2),
    .rd_idx   (in_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  always_ff @(posedge Clk) begin
    if (_Reset) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1;
      out_op2   <= op2;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only hazard stalls are counted; backpressure-only stalls are not.
  always_ff @(posedge Clk) begin
    if (_Reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
